bitwidth_agc_ctrl: RTL

//  Run-time requantiser with a frame-based automatic shift (gain) controller for complex bins.

---
 rtl/bitwidth_agc_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bitwidth_agc_ctrl.sv
// bitwidth_agc_ctrl
//   Run-time requantiser for complex bins with a frame-based automatic shift
//   (gain) controller. Each IW-bit re/im component is arithmetically shifted
//   right by sel_o and saturated to OW bits. Saturation and headroom are
//   collected over a frame of N valid bins. At the end of each frame, sel_o
//   may step by +1 or -1.
//
//   Optional feature macro: BITWIDTH_AGC_STATS_EN
//     When defined, the stat_cnt_o and stat_quiet_o ports are added. They
//     publish each frame's saturation total and quiet flag alongside
//     frame_end_o.
//
//   Reset is asserted asynchronously. rst_n_i is expected to be released
//   synchronously to clk_i by the surrounding reset synchroniser.

module bitwidth_agc_ctrl #(
  parameter int IW          = 16,
  parameter int OW          = 12,
  parameter int N           = 256,
  parameter int SAT_LIMIT   = 4,
  parameter int HOLD_FRAMES = 2,
  parameter int INIT_SEL    = 0,
  localparam int SW         = $clog2(IW - OW + 1),
  localparam int CW         = $clog2(N + 1)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  input  logic [2*IW-1:0] data_i,
  input  logic            freeze_i,
  output logic            valid_o,
  output logic [2*OW-1:0] data_o,
  output logic            sat_o,
  output logic [SW-1:0]   sel_o,
  output logic            frame_end_o
`ifdef BITWIDTH_AGC_STATS_EN
  ,
  output logic [CW-1:0]   stat_cnt_o,
  output logic            stat_quiet_o
`endif
);

  // Bin counter width. N >= 2 keeps this at least one bit wide.
  localparam int BW = $clog2(N);
  // hold_cnt must be at least one bit wide, even when HOLD_FRAMES is 0.
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam int SEL_MAX_I = IW - OW;
  localparam int OMAX_I    = (2 ** (OW - 1)) - 1;
  localparam int QMAX_I    = (2 ** (OW - 2)) - 1;

  // Clip limits and headroom limits, expressed at the input width.
  localparam logic signed [IW-1:0] OMAX_V = IW'(OMAX_I);
  localparam logic signed [IW-1:0] OMIN_V = IW'(-OMAX_I - 1);
  localparam logic signed [IW-1:0] QMAX_V = IW'(QMAX_I);
  localparam logic signed [IW-1:0] QMIN_V = IW'(-QMAX_I - 1);

  localparam logic [SW-1:0] SEL_MAX  = SW'(SEL_MAX_I);
  localparam logic [SW-1:0] SEL_INIT = SW'(INIT_SEL);
  localparam logic [CW-1:0] SAT_MAX  = '1;
  localparam logic [BW-1:0] BIN_LAST = BW'(N - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Saturate a shifted component to OW bits. The MSB of the result flags clipping.
  function automatic logic [OW:0] clip_comp(input logic signed [IW-1:0] x);
    logic [OW:0] r;
    if (x > OMAX_V) begin
      r = {1'b1, OMAX_V[OW-1:0]};
    end else if (x < OMIN_V) begin
      r = {1'b1, OMIN_V[OW-1:0]};
    end else begin
      r = {1'b0, x[OW-1:0]};
    end
    return r;
  endfunction

  // A component is quiet when it would still fit in OW-1 signed bits.
  function automatic logic fits_quiet(input logic signed [IW-1:0] x);
    return (x >= QMIN_V) && (x <= QMAX_V);
  endfunction

  // Architectural state
  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [BW-1:0]   bin_cnt_q, bin_cnt_d;
  logic [CW-1:0]   sat_cnt_q, sat_cnt_d;
  logic            quiet_q, quiet_d;

  // Output registers
  logic            valid_q, valid_d;
  logic [2*OW-1:0] data_q, data_d;
  logic            sat_q, sat_d;
  logic            frame_end_q, frame_end_d;

  // Per-beat datapath
  logic signed [IW-1:0] re_in, im_in, re_sh, im_sh;
  logic [OW-1:0]        re_out, im_out;
  logic                 re_sat, im_sat;
  logic                 beat_sat, beat_quiet;

  // Frame decision terms
  logic                 last;
  logic [CW-1:0]        sat_tot;
  logic                 quiet_tot;
  logic                 inc_cond, dec_cond;

  assign re_in = data_i[IW-1:0];
  assign im_in = data_i[2*IW-1:IW];
  assign re_sh = re_in >>> sel_q;
  assign im_sh = im_in >>> sel_q;

  // Requantise both components and classify the beat for the frame statistics.
  always_comb begin
    {re_sat, re_out} = clip_comp(re_sh);
    {im_sat, im_out} = clip_comp(im_sh);
    beat_sat   = re_sat | im_sat;
    beat_quiet = fits_quiet(re_sh) & fits_quiet(im_sh);
  end

  // Frame totals include the current beat, so the decision sees the full frame.
  always_comb begin
    last      = valid_i && (bin_cnt_q == BIN_LAST);
    quiet_tot = quiet_q & beat_quiet;
    if (sat_cnt_q == SAT_MAX) begin
      sat_tot = SAT_MAX;
    end else begin
      sat_tot = sat_cnt_q + CW'(beat_sat);
    end
    inc_cond = (32'(sat_tot) > 32'(SAT_LIMIT)) && (sel_q < SEL_MAX);
    dec_cond = (state_q == TRACK) && quiet_tot && (sel_q != '0);
  end

  // Advance the bin counter and accumulate statistics. Clear both at frame end.
  always_comb begin
    bin_cnt_d = bin_cnt_q;
    sat_cnt_d = sat_cnt_q;
    quiet_d   = quiet_q;
    if (valid_i) begin
      if (last) begin
        bin_cnt_d = '0;
        sat_cnt_d = '0;
        quiet_d   = 1'b1;
      end else begin
        bin_cnt_d = bin_cnt_q + 1'b1;
        sat_cnt_d = sat_tot;
        quiet_d   = quiet_tot;
      end
    end
  end

  // Output stage. data_o and sat_o hold their values between valid beats.
  always_comb begin
    valid_d     = valid_i;
    frame_end_d = last;
    data_d      = data_q;
    sat_d       = sat_q;
    if (valid_i) begin
      data_d = {im_out, re_out};
      sat_d  = beat_sat;
    end
  end

  // FSM state register, together with the frame statistics and output flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= TRACK;
      sel_q       <= SEL_INIT;
      hold_cnt_q  <= '0;
      bin_cnt_q   <= '0;
      sat_cnt_q   <= '0;
      quiet_q     <= 1'b1;
      valid_q     <= 1'b0;
      data_q      <= '0;
      sat_q       <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      hold_cnt_q  <= hold_cnt_d;
      bin_cnt_q   <= bin_cnt_d;
      sat_cnt_q   <= sat_cnt_d;
      quiet_q     <= quiet_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      sat_q       <= sat_d;
      frame_end_q <= frame_end_d;
    end
  end

  // Next state. An increment re-arms the hold window; HOLD otherwise counts down to TRACK.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (last) begin
      if (inc_cond) begin
        hold_cnt_d = HOLD_INIT;
        state_d    = (HOLD_FRAMES == 0) ? TRACK : HOLD;
      end else if (state_q == HOLD) begin
        if (hold_cnt_q <= HW'(1)) begin
          hold_cnt_d = '0;
          state_d    = TRACK;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
    end
  end

  // FSM output: step the shift at frame end unless frozen. Both ends are clamped by inc/dec terms.
  always_comb begin
    sel_d = sel_q;
    if (last && !freeze_i) begin
      if (inc_cond) begin
        sel_d = sel_q + 1'b1;
      end else if (dec_cond) begin
        sel_d = sel_q - 1'b1;
      end
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign sat_o       = sat_q;
  assign sel_o       = sel_q;
  assign frame_end_o = frame_end_q;

`ifdef BITWIDTH_AGC_STATS_EN
  logic [CW-1:0] stat_cnt_q, stat_cnt_d;
  logic          stat_quiet_q, stat_quiet_d;

  // Capture the completed frame's statistics so they align with frame_end_o.
  always_comb begin
    stat_cnt_d   = stat_cnt_q;
    stat_quiet_d = stat_quiet_q;
    if (last) begin
      stat_cnt_d   = sat_tot;
      stat_quiet_d = quiet_tot;
    end
  end

  // Statistics output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_cnt_q   <= '0;
      stat_quiet_q <= 1'b0;
    end else begin
      stat_cnt_q   <= stat_cnt_d;
      stat_quiet_q <= stat_quiet_d;
    end
  end

  assign stat_cnt_o   = stat_cnt_q;
  assign stat_quiet_o = stat_quiet_q;
`endif

endmodule
